register_bank_arbiter: RTL

- Shares a bank of NrOfRegs tri-state-output register instances (common read bus, common D bus) among NrOfRequesters masters.
- Performs round-robin arbitration and generates each register's chip-select (cs, 1 = output high-Z) and ClockEnable.
- Runs a one-access-at-a-time req/gnt/done handshake.
- Accesses are paced by the global Tick, the same Tick that drives the registers.

---
 rtl/register_bank_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/register_bank_arbiter.sv
// Round-robin arbiter that shares a bank of tri-state-output registers among
// several masters. It owns the per-register chip-selects (cs, 1 = output high-Z)
// and clock-enables, and runs one access at a time paced by the global Tick.
module register_bank_arbiter #(
  parameter int unsigned NrOfRequesters = 4,
  parameter int unsigned NrOfRegs       = 8,
  parameter int unsigned NrOfBits       = 8,
  parameter int unsigned AddrBits       = 3
) (
  input  logic                                Clock,
  input  logic                                Reset,
  input  logic                                Tick,
  input  logic [NrOfRequesters-1:0]           req,
  input  logic [NrOfRequesters-1:0]           we,
  input  logic [NrOfRequesters*AddrBits-1:0]  addr,
  input  logic [NrOfRequesters*NrOfBits-1:0]  wdata,
  output logic [NrOfRequesters-1:0]           gnt,
  output logic [NrOfRequesters-1:0]           done,
  output logic                                err,
  output logic [NrOfBits-1:0]                 rdata,
  output logic [NrOfRegs-1:0]                 reg_cs,
  output logic [NrOfRegs-1:0]                 reg_ce,
  output logic [NrOfBits-1:0]                 reg_d,
  input  logic [NrOfBits-1:0]                 reg_q
);

  localparam int unsigned PtrBits = (NrOfRequesters > 1) ? $clog2(NrOfRequesters) : 1;
  // One extra bit so NrOfRegs == 2^AddrBits still compares correctly.
  localparam logic [AddrBits:0] RegLimit = (AddrBits + 1)'(NrOfRegs);
  localparam logic [PtrBits-1:0] LastReq = PtrBits'(NrOfRequesters - 1);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [PtrBits-1:0]   ptr_q, ptr_d;
  logic [PtrBits-1:0]   winner_q, winner_d;
  logic [PtrBits-1:0]   pick;
  logic [PtrBits-1:0]   cand;
  logic                 pick_valid;
  logic                 we_q;
  logic [AddrBits-1:0]  addr_q;
  logic [NrOfBits-1:0]  wdata_q;
  logic [NrOfBits-1:0]  rdata_q;
  logic                 in_range;

  // Index 'off' places above 'base', wrapping at NrOfRequesters.
  function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off);
    int unsigned sum;
    sum = base + off;
    return (sum >= NrOfRequesters) ? sum - NrOfRequesters : sum;
  endfunction

  assign in_range = ({1'b0, addr_q} < RegLimit);

  // Round-robin search: first requesting master at or above the pointer.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < NrOfRequesters; i++) begin
      cand = PtrBits'(wrap_add(32'(ptr_q), i));
      if (!pick_valid && req[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Next-state logic for the access sequencer and the round-robin pointer.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          winner_d = pick;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        if (Tick) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Move past the master just served so it gets lowest priority next.
        ptr_d   = (winner_q == LastReq) ? '0 : winner_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, pointer and winner registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
    end
  end

  // Capture the winner's command at grant; later input changes are ignored.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == StIdle && pick_valid) begin
      we_q    <= we[pick];
      addr_q  <= addr[pick*AddrBits +: AddrBits];
      wdata_q <= wdata[pick*NrOfBits +: NrOfBits];
    end
  end

  // Read data is sampled on the Tick edge that ends a read access.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rdata_q <= '0;
    end else if (state_q == StAccess && Tick && !we_q) begin
      rdata_q <= in_range ? reg_q : '0;
    end
  end

  assign rdata = rdata_q;

  // Grant, completion and register-bank strobes decoded from the state.
  always_comb begin
    gnt    = '0;
    done   = '0;
    err    = 1'b0;
    reg_cs = '1;
    reg_ce = '0;
    reg_d  = '0;
    if (state_q != StIdle) begin
      gnt[winner_q] = 1'b1;
    end
    if (state_q == StDone) begin
      done[winner_q] = 1'b1;
      err            = !in_range;
    end
    if (state_q == StAccess) begin
      if (we_q) begin
        reg_d = wdata_q;
      end
      // Out-of-range addresses match no register, so nothing is selected.
      for (int unsigned k = 0; k < NrOfRegs; k++) begin
        if (in_range && addr_q == AddrBits'(k)) begin
          if (we_q) begin
            reg_ce[k] = 1'b1;
          end else begin
            reg_cs[k] = 1'b0;
          end
        end
      end
    end
  end

endmodule
